// File: rtl/jelly2_buffer_arbiter_mw.sv
// Multi-writer / multi-reader frame-buffer allocator with per-buffer reference counts.
// Publishes the last completed writer buffer as "newest"; unseen-mode readers get each frame at most once.
module jelly2_buffer_arbiter_mw #(
  parameter int                    BUFFER_NUM    = 4,
  parameter int                    WRITER_NUM    = 2,
  parameter int                    READER_NUM    = 2,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    REFCNT_WIDTH  = 4,
  parameter int                    INDEX_WIDTH   = $clog2(BUFFER_NUM),
  parameter logic [READER_NUM-1:0] READER_UNSEEN = '0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cke,
  input  logic [BUFFER_NUM*ADDR_WIDTH-1:0]   param_buf_addr,
  input  logic [WRITER_NUM-1:0]              writer_request,
  input  logic [WRITER_NUM-1:0]              writer_release,
  output logic [WRITER_NUM-1:0]              writer_valid,
  output logic [WRITER_NUM*ADDR_WIDTH-1:0]   writer_addr,
  output logic [WRITER_NUM*INDEX_WIDTH-1:0]  writer_index,
  input  logic [READER_NUM-1:0]              reader_request,
  input  logic [READER_NUM-1:0]              reader_release,
  output logic [READER_NUM-1:0]              reader_valid,
  output logic [READER_NUM*ADDR_WIDTH-1:0]   reader_addr,
  output logic [READER_NUM*INDEX_WIDTH-1:0]  reader_index,
  output logic                               newest_valid,
  output logic [ADDR_WIDTH-1:0]              newest_addr,
  output logic [INDEX_WIDTH-1:0]             newest_index,
  output logic [15:0]                        writer_fail_count,
  output logic [BUFFER_NUM*REFCNT_WIDTH-1:0] status_refcnt
);

  localparam int REFCNT_MAX = (1 << REFCNT_WIDTH) - 1;

  logic [WRITER_NUM-1:0]   w_valid_q, w_valid_d;
  logic [INDEX_WIDTH-1:0]  w_index_q [WRITER_NUM];
  logic [INDEX_WIDTH-1:0]  w_index_d [WRITER_NUM];
  logic [READER_NUM-1:0]   r_valid_q, r_valid_d;
  logic [INDEX_WIDTH-1:0]  r_index_q [READER_NUM];
  logic [INDEX_WIDTH-1:0]  r_index_d [READER_NUM];
  logic [READER_NUM-1:0]   seen_q, seen_d;
  logic [REFCNT_WIDTH-1:0] refcnt_q [BUFFER_NUM];
  logic [REFCNT_WIDTH-1:0] refcnt_d [BUFFER_NUM];
  logic                    newest_valid_q, newest_valid_d;
  logic [INDEX_WIDTH-1:0]  newest_index_q, newest_index_d;
  logic [15:0]             fail_q, fail_d;

  logic [BUFFER_NUM-1:0]   avail;
  int                      inc_cnt [BUFFER_NUM];
  int                      dec_cnt [BUFFER_NUM];
  logic                    found;
  logic [INDEX_WIDTH-1:0]  found_idx;
  logic                    publish;
  logic [INDEX_WIDTH-1:0]  publish_idx;
  int                      fail_inc;
  int                      sum;
  logic [ADDR_WIDTH-1:0]   buf_addr [BUFFER_NUM];

  always_comb begin
    w_valid_d      = w_valid_q;
    w_index_d      = w_index_q;
    r_valid_d      = r_valid_q;
    r_index_d      = r_index_q;
    seen_d         = seen_q;
    refcnt_d       = refcnt_q;
    newest_valid_d = newest_valid_q;
    newest_index_d = newest_index_q;
    fail_d         = fail_q;
    found          = 1'b0;
    found_idx      = '0;
    publish        = 1'b0;
    publish_idx    = '0;
    fail_inc       = 0;
    sum            = 0;

    // Free set is taken from pre-cycle state only, so buffers released now wait a cycle.
    for (int b = 0; b < BUFFER_NUM; b++) begin
      inc_cnt[b] = 0;
      dec_cnt[b] = 0;
      avail[b]   = (refcnt_q[b] == '0) &&
                   !(newest_valid_q && newest_index_q == INDEX_WIDTH'(b));
    end

    // Ascending order: lowest writer picks first, highest releasing writer publishes last.
    for (int w = 0; w < WRITER_NUM; w++) begin
      if (writer_release[w]) begin
        if (w_valid_q[w]) begin
          w_valid_d[w]          = 1'b0;
          dec_cnt[w_index_q[w]] = dec_cnt[w_index_q[w]] + 1;
          publish               = 1'b1;
          publish_idx           = w_index_q[w];
        end
      end else if (writer_request[w] && !w_valid_q[w]) begin
        found     = 1'b0;
        found_idx = '0;
        for (int b = 0; b < BUFFER_NUM; b++) begin
          if (!found && avail[b]) begin
            found     = 1'b1;
            found_idx = INDEX_WIDTH'(b);
          end
        end
        if (found) begin
          avail[found_idx]   = 1'b0;
          w_valid_d[w]       = 1'b1;
          w_index_d[w]       = found_idx;
          inc_cnt[found_idx] = inc_cnt[found_idx] + 1;
        end else begin
          fail_inc = fail_inc + 1;
        end
      end
    end

    for (int r = 0; r < READER_NUM; r++) begin
      if (reader_release[r]) begin
        if (r_valid_q[r]) begin
          r_valid_d[r]          = 1'b0;
          dec_cnt[r_index_q[r]] = dec_cnt[r_index_q[r]] + 1;
        end
      end else if (reader_request[r] && !r_valid_q[r] && newest_valid_q &&
                   !(READER_UNSEEN[r] && seen_q[r])) begin
        r_valid_d[r]            = 1'b1;
        r_index_d[r]            = newest_index_q;
        inc_cnt[newest_index_q] = inc_cnt[newest_index_q] + 1;
        if (READER_UNSEEN[r]) seen_d[r] = 1'b1;
      end
    end

    if (publish) begin
      newest_valid_d = 1'b1;
      newest_index_d = publish_idx;
      seen_d         = '0;
    end

    for (int b = 0; b < BUFFER_NUM; b++) begin
      sum = int'(refcnt_q[b]) + inc_cnt[b] - dec_cnt[b];
      if (sum > REFCNT_MAX) sum = REFCNT_MAX;
      if (sum < 0)          sum = 0;
      refcnt_d[b] = REFCNT_WIDTH'(sum);
    end

    sum = int'(fail_q) + fail_inc;
    if (sum > 65535) sum = 65535;
    fail_d = 16'(sum);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_valid_q      <= '0;
      r_valid_q      <= '0;
      seen_q         <= '0;
      newest_valid_q <= 1'b0;
      newest_index_q <= '0;
      fail_q         <= '0;
      for (int w = 0; w < WRITER_NUM; w++) w_index_q[w] <= '0;
      for (int r = 0; r < READER_NUM; r++) r_index_q[r] <= '0;
      for (int b = 0; b < BUFFER_NUM; b++) refcnt_q[b] <= '0;
    end else if (cke) begin
      w_valid_q      <= w_valid_d;
      r_valid_q      <= r_valid_d;
      seen_q         <= seen_d;
      newest_valid_q <= newest_valid_d;
      newest_index_q <= newest_index_d;
      fail_q         <= fail_d;
      for (int w = 0; w < WRITER_NUM; w++) w_index_q[w] <= w_index_d[w];
      for (int r = 0; r < READER_NUM; r++) r_index_q[r] <= r_index_d[r];
      for (int b = 0; b < BUFFER_NUM; b++) refcnt_q[b] <= refcnt_d[b];
    end
  end

  for (genvar b = 0; b < BUFFER_NUM; b++) begin : g_buf
    assign buf_addr[b] = param_buf_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign status_refcnt[b*REFCNT_WIDTH +: REFCNT_WIDTH] = refcnt_q[b];
  end

  for (genvar w = 0; w < WRITER_NUM; w++) begin : g_wr
    assign writer_index[w*INDEX_WIDTH +: INDEX_WIDTH] = w_index_q[w];
    assign writer_addr[w*ADDR_WIDTH +: ADDR_WIDTH]    = buf_addr[w_index_q[w]];
  end

  for (genvar r = 0; r < READER_NUM; r++) begin : g_rd
    assign reader_index[r*INDEX_WIDTH +: INDEX_WIDTH] = r_index_q[r];
    assign reader_addr[r*ADDR_WIDTH +: ADDR_WIDTH]    = buf_addr[r_index_q[r]];
  end

  assign writer_valid      = w_valid_q;
  assign reader_valid      = r_valid_q;
  assign newest_valid      = newest_valid_q;
  assign newest_index      = newest_index_q;
  assign newest_addr       = buf_addr[newest_index_q];
  assign writer_fail_count = fail_q;

endmodule

// File: tb/tb_jelly2_buffer_arbiter_mw.sv
// Scoreboard bench: a holder-tracking reference model predicts every post-edge snapshot,
// and an independent monitor compares it with the DUT on each falling edge.
module tb_jelly2_buffer_arbiter_mw;
  localparam int BN = 4;
  localparam int WN = 2;
  localparam int RN = 2;
  localparam int AW = 32;
  localparam int RW = 4;
  localparam int IW = 2;
  localparam logic [RN-1:0] UNSEEN = 2'b10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cke = 1'b1;
  logic [BN*AW-1:0] param_buf_addr;
  logic [WN-1:0] writer_request = '0, writer_release = '0, writer_valid;
  logic [WN*AW-1:0] writer_addr;
  logic [WN*IW-1:0] writer_index;
  logic [RN-1:0] reader_request = '0, reader_release = '0, reader_valid;
  logic [RN*AW-1:0] reader_addr;
  logic [RN*IW-1:0] reader_index;
  logic newest_valid;
  logic [AW-1:0] newest_addr;
  logic [IW-1:0] newest_index;
  logic [15:0] writer_fail_count;
  logic [BN*RW-1:0] status_refcnt;

  jelly2_buffer_arbiter_mw #(
    .BUFFER_NUM(BN), .WRITER_NUM(WN), .READER_NUM(RN), .ADDR_WIDTH(AW),
    .REFCNT_WIDTH(RW), .INDEX_WIDTH(IW), .READER_UNSEEN(UNSEEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke), .param_buf_addr(param_buf_addr),
    .writer_request(writer_request), .writer_release(writer_release),
    .writer_valid(writer_valid), .writer_addr(writer_addr), .writer_index(writer_index),
    .reader_request(reader_request), .reader_release(reader_release),
    .reader_valid(reader_valid), .reader_addr(reader_addr), .reader_index(reader_index),
    .newest_valid(newest_valid), .newest_addr(newest_addr), .newest_index(newest_index),
    .writer_fail_count(writer_fail_count), .status_refcnt(status_refcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WN-1:0]    wv;
    logic [WN*IW-1:0] widx;
    logic [WN*AW-1:0] waddr;
    logic [RN-1:0]    rv;
    logic [RN*IW-1:0] ridx;
    logic [RN*AW-1:0] raddr;
    logic             nv;
    logic [IW-1:0]    ni;
    logic [AW-1:0]    naddr;
    logic [15:0]      fail;
    logic [BN*RW-1:0] rc;
  } snap_t;

  snap_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] paddr [BN];

  // Reference state: who holds what; refcnt is derived as the number of holders.
  bit m_wh [WN];
  int m_wi [WN];
  bit m_rh [RN];
  int m_ri [RN];
  bit m_seen [RN];
  bit m_nv;
  int m_ni;
  int m_fail;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [WN-1:0] wq, input logic [WN-1:0] wl,
                            input logic [RN-1:0] rq, input logic [RN-1:0] rl,
                            input logic ce, input logic rn);
    int  holders [BN];
    bit  taken [BN];
    bit  nseen [RN];
    int  pub;
    int  g;
    if (!rn) begin
      for (int w = 0; w < WN; w++) begin m_wh[w] = 0; m_wi[w] = 0; end
      for (int r = 0; r < RN; r++) begin m_rh[r] = 0; m_ri[r] = 0; m_seen[r] = 0; end
      m_nv = 0; m_ni = 0; m_fail = 0;
      return;
    end
    if (!ce) return;
    for (int b = 0; b < BN; b++) begin holders[b] = 0; taken[b] = 0; end
    for (int w = 0; w < WN; w++) if (m_wh[w]) holders[m_wi[w]]++;
    for (int r = 0; r < RN; r++) if (m_rh[r]) holders[m_ri[r]]++;
    for (int b = 0; b < BN; b++) if (m_nv && m_ni == b) taken[b] = 1;
    pub = -1;
    for (int w = 0; w < WN; w++) begin
      if (wl[w]) begin
        if (m_wh[w]) begin m_wh[w] = 0; pub = m_wi[w]; end
      end else if (wq[w] && !m_wh[w]) begin
        g = -1;
        for (int b = 0; b < BN; b++) if (g < 0 && holders[b] == 0 && !taken[b]) g = b;
        if (g >= 0) begin taken[g] = 1; m_wh[w] = 1; m_wi[w] = g; end
        else if (m_fail < 65535) m_fail++;
      end
    end
    for (int r = 0; r < RN; r++) begin
      nseen[r] = m_seen[r];
      if (rl[r]) begin
        if (m_rh[r]) m_rh[r] = 0;
      end else if (rq[r] && !m_rh[r] && m_nv && !(UNSEEN[r] && m_seen[r])) begin
        m_rh[r] = 1; m_ri[r] = m_ni;
        if (UNSEEN[r]) nseen[r] = 1;
      end
    end
    for (int r = 0; r < RN; r++) m_seen[r] = (pub >= 0) ? 1'b0 : nseen[r];
    if (pub >= 0) begin m_nv = 1; m_ni = pub; end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    int cnt;
    for (int w = 0; w < WN; w++) begin
      s.wv[w] = m_wh[w];
      s.widx[w*IW +: IW] = IW'(m_wi[w]);
      s.waddr[w*AW +: AW] = paddr[m_wi[w]];
    end
    for (int r = 0; r < RN; r++) begin
      s.rv[r] = m_rh[r];
      s.ridx[r*IW +: IW] = IW'(m_ri[r]);
      s.raddr[r*AW +: AW] = paddr[m_ri[r]];
    end
    s.nv = m_nv;
    s.ni = IW'(m_ni);
    s.naddr = paddr[m_ni];
    s.fail = 16'(m_fail);
    for (int b = 0; b < BN; b++) begin
      cnt = 0;
      for (int w = 0; w < WN; w++) if (m_wh[w] && m_wi[w] == b) cnt++;
      for (int r = 0; r < RN; r++) if (m_rh[r] && m_ri[r] == b) cnt++;
      s.rc[b*RW +: RW] = RW'(cnt);
    end
    return s;
  endfunction

  task automatic drive(input logic [WN-1:0] wq, input logic [WN-1:0] wl,
                       input logic [RN-1:0] rq, input logic [RN-1:0] rl,
                       input logic ce, input logic rn);
    @(negedge clk);
    writer_request = wq; writer_release = wl;
    reader_request = rq; reader_release = rl;
    cke = ce; reset_n = rn;
    model_step(wq, wl, rq, rl, ce, rn);
    @(posedge clk);
    #1;
    sb_q.push_back(model_snap());
  endtask

  task automatic step(input logic [WN-1:0] wq, input logic [WN-1:0] wl,
                      input logic [RN-1:0] rq, input logic [RN-1:0] rl);
    drive(wq, wl, rq, rl, 1'b1, 1'b1);
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("writer_valid", 128'(writer_valid), 128'(e.wv));
        cmp("writer_index", 128'(writer_index), 128'(e.widx));
        cmp("writer_addr", 128'(writer_addr), 128'(e.waddr));
        cmp("reader_valid", 128'(reader_valid), 128'(e.rv));
        cmp("reader_index", 128'(reader_index), 128'(e.ridx));
        cmp("reader_addr", 128'(reader_addr), 128'(e.raddr));
        cmp("newest_valid", 128'(newest_valid), 128'(e.nv));
        cmp("newest_index", 128'(newest_index), 128'(e.ni));
        cmp("newest_addr", 128'(newest_addr), 128'(e.naddr));
        cmp("fail_count", 128'(writer_fail_count), 128'(e.fail));
        cmp("status_refcnt", 128'(status_refcnt), 128'(e.rc));
      end
    end
  end

  initial begin : stimulus
    logic [WN-1:0] wq, wl;
    logic [RN-1:0] rq, rl;
    for (int b = 0; b < BN; b++) begin
      paddr[b] = $urandom;
      param_buf_addr[b*AW +: AW] = paddr[b];
    end

    // Single writer acquire / publish
    drive('0, '0, '0, '0, 1'b1, 1'b0);
    step(2'b01, '0, '0, '0);
    cmp("t1_wvalid", 128'(writer_valid[0]), 128'(1));
    cmp("t1_refcnt0", 128'(status_refcnt[RW-1:0]), 128'(1));
    step('0, 2'b01, '0, '0);
    cmp("t1_newest", 128'({newest_valid, newest_index}), 128'({1'b1, 2'd0}));

    // Two writers together, highest releaser wins newest
    drive('0, '0, '0, '0, 1'b1, 1'b0);
    step(2'b11, '0, '0, '0);
    cmp("t2_windex", 128'(writer_index), 128'({2'd1, 2'd0}));
    step('0, 2'b11, '0, '0);
    cmp("t2_newest", 128'(newest_index), 128'(1));
    cmp("t2_refcnt", 128'(status_refcnt), 128'(0));

    // Newest=2, newest-mode and unseen-mode readers
    drive('0, '0, '0, '0, 1'b1, 1'b0);
    step(2'b11, '0, '0, '0);
    step('0, 2'b10, '0, '0);
    step(2'b10, '0, '0, '0);
    step('0, 2'b10, '0, '0);
    cmp("t3_newest2", 128'(newest_index), 128'(2));
    step('0, '0, 2'b01, '0);
    cmp("t3_r0_idx", 128'(reader_index[IW-1:0]), 128'(2));
    step('0, '0, '0, 2'b01);
    cmp("t3_rc2_zero", 128'(status_refcnt[2*RW +: RW]), 128'(0));
    step('0, '0, 2'b11, '0);
    step('0, '0, '0, 2'b10);
    step('0, '0, 2'b10, '0);
    cmp("t3_unseen_blocked", 128'(reader_valid[1]), 128'(0));
    step('0, 2'b01, '0, '0);
    step('0, '0, 2'b10, '0);
    cmp("t3_unseen_new", 128'({reader_valid[1], reader_index[IW +: IW]}), 128'({1'b1, 2'd0}));

    // Exhaust buffers: reader0 holds 0, reader1 holds 1, newest 2, writer0 holds 3
    drive('0, '0, '0, '0, 1'b1, 1'b0);
    step(2'b01, '0, '0, '0);
    step('0, 2'b01, '0, '0);
    step('0, '0, 2'b01, '0);
    step(2'b11, '0, '0, '0);
    cmp("t4_w1_idx", 128'(writer_index[IW +: IW]), 128'(2));
    step('0, 2'b01, '0, '0);
    step(2'b01, '0, '0, '0);
    step('0, '0, 2'b10, '0);
    step('0, 2'b10, '0, '0);
    step(2'b10, '0, '0, '0);
    cmp("t4_fail", 128'(writer_fail_count), 128'(1));

    // Same-port request+release, spurious releases, cke hold, mid-run reset
    step(2'b01, 2'b11, 2'b01, 2'b11);
    step('0, '0, '0, '0);
    drive(2'b11, '0, 2'b11, '0, 1'b0, 1'b1);
    drive(2'b11, '0, '0, '0, 1'b1, 1'b0);
    cmp("t5_reset", 128'({writer_valid, reader_valid, newest_valid, status_refcnt}), 128'(0));

    for (int i = 0; i < 1500; i++) begin
      for (int w = 0; w < WN; w++) begin
        wq[w] = ($urandom % 10) < 3;
        wl[w] = ($urandom % 10) < 2;
      end
      for (int r = 0; r < RN; r++) begin
        rq[r] = ($urandom % 10) < 3;
        rl[r] = ($urandom % 10) < 2;
      end
      drive(wq, wl, rq, rl, ($urandom % 10) != 0, ($urandom % 200) != 0);
    end
    step('0, '0, '0, '0);
    repeat (2) @(negedge clk);
    #1;
    cmp("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
